// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_pkg
//  Brief    : Shared types and helpers for the direct-mapped cache controller:
//             FSM state encoding, geometry derivation, statistics width.
//  Revision : 1.0  initial release
// ============================================================================
package cache_pkg;

    // Controller states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOKUP   = 2'd1,
        MEM_WAIT = 2'd2,
        WR_DONE  = 2'd3
    } cache_state_t;

    // Width of the hit/miss statistics counters
    localparam int STAT_W = 16;

    // Tag width left over once the index bits are taken from the word address
    function automatic int calc_tag_w(input int addr_w, input int index_w);
        return addr_w - index_w;
    endfunction

    // Number of lines addressed by the index field
    function automatic int calc_lines(input int index_w);
        return 1 << index_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_store.sv
`default_nettype none
// ============================================================================
//  Module   : cache_line_store
//  Brief    : LINES x {valid, tag, data} storage with one combinational read
//             port and one synchronous write port. Valid bits clear on reset;
//             tag and data contents are don't-care until their line is valid.
//  Revision : 1.0  initial release
// ============================================================================
module cache_line_store
    import cache_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int INDEX_W = 2,
    parameter int TAG_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [WIDTH-1:0]   rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [WIDTH-1:0]   wr_data
);

    localparam int LINES = calc_lines(INDEX_W);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [WIDTH-1:0] r_data [LINES];

    // Valid bits: cleared on reset, set when a line is filled or written
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data payload: written alongside the valid bit
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[wr_idx]  <= wr_tag;
            r_data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = r_valid[rd_idx];
    assign rd_tag   = r_tag[rd_idx];
    assign rd_data  = r_data[rd_idx];

endmodule
`default_nettype wire

// File: rtl/cache_ctrl_dm.sv
`default_nettype none
// ============================================================================
//  Module   : cache_ctrl_dm
//  Brief    : Direct-mapped, one-word-per-line, write-through/write-allocate
//             cache controller; sole initiator of the backing Ram.
//             Optional macro CACHE_STATS_EN adds saturating hit/miss counters
//             (stat_hits / stat_misses).
//  Revision : 1.0  initial release
// ============================================================================
module cache_ctrl_dm
    import cache_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 4,
    parameter int INDEX_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WIDTH-1:0]  cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [WIDTH-1:0]  cpu_rdata,
    output logic              cpu_hit,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_valid
`ifdef CACHE_STATS_EN
   ,output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_misses
`endif
);

    localparam int TAG_W = calc_tag_w(ADDR_W, INDEX_W);

    cache_state_t      r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [WIDTH-1:0]  r_wdata;
    logic              r_wr_hit;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_rd_valid;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [WIDTH-1:0]   w_rd_data;
    logic               w_hit;
    logic               w_line_we;
    logic [WIDTH-1:0]   w_line_data;

    assign w_idx = r_addr[INDEX_W-1:0];
    assign w_tag = r_addr[ADDR_W-1:INDEX_W];
    assign w_hit = w_rd_valid && (w_rd_tag == w_tag);

    // Writes allocate in LOOKUP; read misses fill when Ram answers
    assign w_line_we   = ((r_state == LOOKUP) && r_we) ||
                         ((r_state == MEM_WAIT) && mem_valid);
    assign w_line_data = r_we ? r_wdata : mem_rdata;

    cache_line_store #(
        .WIDTH   (WIDTH),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_store (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (w_idx),
        .rd_valid (w_rd_valid),
        .rd_tag   (w_rd_tag),
        .rd_data  (w_rd_data),
        .wr_en    (w_line_we),
        .wr_idx   (w_idx),
        .wr_tag   (w_tag),
        .wr_data  (w_line_data)
    );

    // Request FSM with registered CPU and Ram-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_wr_hit  <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_done  <= 1'b0;
            cpu_hit   <= 1'b0;
            cpu_rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
        end else begin
            // Pulses default low every cycle
            cpu_done <= 1'b0;
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_addr    <= cpu_addr;
                        r_we      <= cpu_we;
                        r_wdata   <= cpu_wdata;
                        cpu_ready <= 1'b0;
                        r_state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (r_we) begin
                        // Write-through: always one Ram write; hit flag is pre-write
                        mem_we    <= 1'b1;
                        mem_addr  <= r_addr;
                        mem_wdata <= r_wdata;
                        r_wr_hit  <= w_hit;
                        r_state   <= WR_DONE;
                    end else if (w_hit) begin
                        cpu_done  <= 1'b1;
                        cpu_hit   <= 1'b1;
                        cpu_rdata <= w_rd_data;
                        cpu_ready <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        mem_re    <= 1'b1;
                        mem_addr  <= r_addr;
                        r_state   <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    // No timeout: Ram is expected to always answer
                    if (mem_valid) begin
                        cpu_done  <= 1'b1;
                        cpu_hit   <= 1'b0;
                        cpu_rdata <= mem_rdata;
                        cpu_ready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                WR_DONE: begin
                    cpu_done  <= 1'b1;
                    cpu_hit   <= r_wr_hit;
                    cpu_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    cpu_ready <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic w_finish;
    logic w_finish_hit;

    // The same conditions that raise cpu_done on this edge, and its hit flag
    assign w_finish = ((r_state == LOOKUP) && !r_we && w_hit) ||
                      ((r_state == MEM_WAIT) && mem_valid) ||
                      (r_state == WR_DONE);
    assign w_finish_hit = (r_state == LOOKUP) ? 1'b1 :
                          (r_state == WR_DONE) ? r_wr_hit : 1'b0;

    // Saturating hit/miss counters, one step per completed request
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (w_finish) begin
            if (w_finish_hit) begin
                if (stat_hits != '1) begin
                    stat_hits <= stat_hits + STAT_W'(1);
                end
            end else begin
                if (stat_misses != '1) begin
                    stat_misses <= stat_misses + STAT_W'(1);
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_dm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_ctrl_dm
//  Brief    : Self-checking bench for cache_ctrl_dm with a behavioural Ram.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cache_ctrl_dm;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_hit;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_valid;
`ifdef CACHE_STATS_EN
    logic [15:0] stat_hits;
    logic [15:0] stat_misses;
`endif

    cache_ctrl_dm #(.WIDTH(32), .ADDR_W(4), .INDEX_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .cpu_hit   (cpu_hit),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid)
`ifdef CACHE_STATS_EN
       ,.stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural Ram: word i preloads to 32'hCAFE000i; answers one cycle after mem_re
    logic [31:0] ram [16];
    logic        ram_load;
    logic        hold_valid;
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'hCAFE_0000 + 32'(i);
            mem_valid <= 1'b0;
            mem_rdata <= '0;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_valid <= mem_re && !hold_valid;
            if (mem_re) mem_rdata <= ram[mem_addr];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Read and write strobes to Ram must never overlap
    always @(negedge clk) begin
        if (!reset && !ram_load) begin
            checks++;
            if (mem_we && mem_re) begin
                errors++;
                $display("FAIL we_re_overlap: got both high expected exclusive");
            end
        end
    end

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_re;
        int          exp_we;
    } vec_t;

    vec_t vecs [14];

    // Issue one request and observe it until cpu_done (bounded)
    task automatic do_req(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                          output int lat, output int n_re, output int n_we,
                          output logic hit, output logic [31:0] data,
                          output logic [3:0] re_addr, output logic [3:0] we_addr,
                          output logic [31:0] we_data, output logic ok);
        int k;
        ok = 1'b0; lat = 0; n_re = 0; n_we = 0; hit = 1'b0; data = '0;
        re_addr = '0; we_addr = '0; we_data = '0;
        k = 0;
        while (!cpu_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_re) begin n_re++; re_addr = mem_addr; end
            if (mem_we) begin n_we++; we_addr = mem_addr; we_data = mem_wdata; end
            if (cpu_done) begin
                lat = c; hit = cpu_hit; data = cpu_rdata; ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int lat, n_re, n_we, cnt;
        logic hit, ok;
        logic [31:0] data, we_data;
        logic [3:0] re_addr, we_addr;

        //          we    addr   wdata          hit   data           lat re we
        vecs[0]  = '{1'b0, 4'h5, 32'h0,         1'b0, 32'hCAFE0005, 3, 1, 0};
        vecs[1]  = '{1'b0, 4'h5, 32'h0,         1'b1, 32'hCAFE0005, 1, 0, 0};
        vecs[2]  = '{1'b1, 4'h9, 32'hDEADBEEF,  1'b0, 32'hCAFE0005, 2, 0, 1};
        vecs[3]  = '{1'b0, 4'h9, 32'h0,         1'b1, 32'hDEADBEEF, 1, 0, 0};
        vecs[4]  = '{1'b0, 4'h1, 32'h0,         1'b0, 32'hCAFE0001, 3, 1, 0};
        vecs[5]  = '{1'b0, 4'h9, 32'h0,         1'b0, 32'hDEADBEEF, 3, 1, 0};
        vecs[6]  = '{1'b1, 4'h9, 32'h12345678,  1'b1, 32'hDEADBEEF, 2, 0, 1};
        vecs[7]  = '{1'b0, 4'h9, 32'h0,         1'b1, 32'h12345678, 1, 0, 0};
        vecs[8]  = '{1'b0, 4'hE, 32'h0,         1'b0, 32'hCAFE000E, 3, 1, 0};
        vecs[9]  = '{1'b1, 4'h2, 32'h0000A0A0,  1'b0, 32'hCAFE000E, 2, 0, 1};
        vecs[10] = '{1'b0, 4'hE, 32'h0,         1'b0, 32'hCAFE000E, 3, 1, 0};
        vecs[11] = '{1'b0, 4'h2, 32'h0,         1'b0, 32'h0000A0A0, 3, 1, 0};
        vecs[12] = '{1'b0, 4'h3, 32'h0,         1'b0, 32'hCAFE0003, 3, 1, 0};
        vecs[13] = '{1'b0, 4'h3, 32'h0,         1'b1, 32'hCAFE0003, 1, 0, 0};

        reset = 1'b1; ram_load = 1'b1; hold_valid = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; ram_load = 1'b0;

        // Reset state
        chk("rst_ready", 32'(cpu_ready), 32'd1);
        chk("rst_done", 32'(cpu_done), 32'd0);
        chk("rst_hit", 32'(cpu_hit), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
`ifdef CACHE_STATS_EN
        chk("rst_stat_hits", 32'(stat_hits), 32'd0);
        chk("rst_stat_misses", 32'(stat_misses), 32'd0);
`endif

        // Table-driven request sequence
        for (int v = 0; v < 14; v++) begin
            do_req(vecs[v].we, vecs[v].addr, vecs[v].wdata,
                   lat, n_re, n_we, hit, data, re_addr, we_addr, we_data, ok);
            chk($sformatf("v%0d_done", v), 32'(ok), 32'd1);
            chk($sformatf("v%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
            chk($sformatf("v%0d_hit", v), 32'(hit), 32'(vecs[v].exp_hit));
            chk($sformatf("v%0d_data", v), data, vecs[v].exp_data);
            chk($sformatf("v%0d_n_re", v), 32'(n_re), 32'(vecs[v].exp_re));
            chk($sformatf("v%0d_n_we", v), 32'(n_we), 32'(vecs[v].exp_we));
            if (vecs[v].exp_re != 0)
                chk($sformatf("v%0d_re_addr", v), 32'(re_addr), 32'(vecs[v].addr));
            if (vecs[v].exp_we != 0) begin
                chk($sformatf("v%0d_we_addr", v), 32'(we_addr), 32'(vecs[v].addr));
                chk($sformatf("v%0d_we_data", v), we_data, vecs[v].wdata);
            end
        end

        // cpu_req held high through a miss: one request per IDLE, no extra mem_re
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'hD; cpu_wdata = '0;
        n_re = 0; lat = 0; ok = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_re) n_re++;
            if (cpu_done) begin lat = c; hit = cpu_hit; data = cpu_rdata; ok = 1'b1; break; end
        end
        chk("hold_done", 32'(ok), 32'd1);
        chk("hold_lat", 32'(lat), 32'd4);
        chk("hold_n_re", 32'(n_re), 32'd1);
        chk("hold_hit", 32'(hit), 32'd0);
        chk("hold_data", data, 32'hCAFE000D);
        // Still requesting in the completion cycle: second request accepted, now a hit
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        n_re = 0; lat = 0; ok = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_re) n_re++;
            if (cpu_done) begin lat = c; hit = cpu_hit; data = cpu_rdata; ok = 1'b1; break; end
        end
        chk("hold2_done", 32'(ok), 32'd1);
        chk("hold2_lat", 32'(lat), 32'd1);
        chk("hold2_hit", 32'(hit), 32'd1);
        chk("hold2_n_re", 32'(n_re), 32'd0);
        chk("hold2_data", data, 32'hCAFE000D);
        // No third request sneaks in once cpu_req is low
        cnt = 0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (cpu_done || mem_re || mem_we) cnt++;
        end
        chk("hold_idle_quiet", 32'(cnt), 32'd0);
`ifdef CACHE_STATS_EN
        chk("stat_hits", 32'(stat_hits), 32'd6);
        chk("stat_misses", 32'(stat_misses), 32'd10);
`endif

        // Reset while waiting in MEM_WAIT aborts the request
        hold_valid = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h6;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_mem_re", 32'(mem_re), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        hold_valid = 1'b0;
        chk("abort_ready", 32'(cpu_ready), 32'd1);
        chk("abort_mem_re_low", 32'(mem_re), 32'd0);
        cnt = 0;
        if (cpu_done) cnt++;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (cpu_done) cnt++;
        end
        chk("abort_no_done", 32'(cnt), 32'd0);
`ifdef CACHE_STATS_EN
        chk("abort_stat_hits", 32'(stat_hits), 32'd0);
        chk("abort_stat_misses", 32'(stat_misses), 32'd0);
`endif
        do_req(1'b0, 4'h6, 32'h0, lat, n_re, n_we, hit, data, re_addr, we_addr, we_data, ok);
        chk("post_abort_done", 32'(ok), 32'd1);
        chk("post_abort_lat", 32'(lat), 32'd3);
        chk("post_abort_hit", 32'(hit), 32'd0);
        chk("post_abort_data", data, 32'hCAFE0006);
        chk("post_abort_n_re", 32'(n_re), 32'd1);
        // Reset also cleared the line holding 0x3, so it misses again
        do_req(1'b0, 4'h3, 32'h0, lat, n_re, n_we, hit, data, re_addr, we_addr, we_data, ok);
        chk("post_abort_3_hit", 32'(hit), 32'd0);
        chk("post_abort_3_data", data, 32'hCAFE0003);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
